// File: rtl/vga_frame_reader.sv
// vga_frame_reader: pixel-write sink with frame store and raster readback.
//
// Captures every vga_plot write into a WIDTH x HEIGHT x 3-bit frame store.
// On start, it streams the stored frame back in raster order over a
// valid/ready handshake. It also counts the non-black pixels in each scan.
//
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   vga_x, vga_y, vga_colour,         - pixel write port (drawer side)
//   vga_plot
//   start                             - begin a readback scan (IDLE only)
//   pix_x, pix_y, pix_colour,         - presented pixel and handshake
//   pix_valid, pix_ready, pix_last
//   busy                              - scan in progress (FETCH or PRESENT)
//   done                              - one-cycle pulse at scan completion
//   lit_count                         - non-black pixels in last completed scan
module vga_frame_reader #(
    parameter int unsigned WIDTH  = 160,
    parameter int unsigned HEIGHT = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        start,
    output logic [7:0]  pix_x,
    output logic [6:0]  pix_y,
    output logic [2:0]  pix_colour,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        busy,
    output logic        done,
    output logic [14:0] lit_count
);

    localparam int unsigned Depth = WIDTH * HEIGHT;
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [7:0]  XLast = 8'(WIDTH - 1);
    localparam logic [6:0]  YLast = 7'(HEIGHT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StPresent,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [14:0] cnt_q, cnt_d;
    logic [14:0] lit_q, lit_d;

    // Frame store: not reset, written in every state.
    logic [2:0]  mem [Depth];
    logic [2:0]  rd_data_q;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [14:0] rd_addr;
    logic        at_last;

    assign wr_en   = vga_plot && (vga_x <= XLast) && (vga_y <= YLast);
    assign wr_addr = 15'(vga_y) * 15'(WIDTH) + 15'(vga_x);
    assign rd_addr = 15'(y_q) * 15'(WIDTH) + 15'(x_q);
    assign at_last = (x_q == XLast) && (y_q == YLast);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[AddrW-1:0]] <= vga_colour;
        end
    end

    // Read port: same-edge writes are not yet visible, so a collision returns old data.
    always_ff @(posedge clk) begin
        if (state_q == StFetch) begin
            rd_data_q <= mem[rd_addr[AddrW-1:0]];
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        lit_d   = lit_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StPresent;
            end
            StPresent: begin
                if (pix_ready) begin
                    if (rd_data_q != 3'd0) begin
                        cnt_d = cnt_q + 15'd1;
                    end
                    if (at_last) begin
                        // Publish on entry to DONE so lit_count is current while done is high.
                        lit_d   = cnt_d;
                        state_d = StDone;
                    end else begin
                        if (x_q == XLast) begin
                            x_d = '0;
                            y_d = y_q + 7'd1;
                        end else begin
                            x_d = x_q + 8'd1;
                        end
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            lit_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            lit_q   <= lit_d;
        end
    end

    assign pix_valid  = (state_q == StPresent);
    assign pix_x      = x_q;
    assign pix_y      = y_q;
    // Gated so the uninitialised read register never leaks out while idle.
    assign pix_colour = pix_valid ? rd_data_q : 3'd0;
    assign pix_last   = pix_valid && at_last;
    assign busy       = (state_q == StFetch) || (state_q == StPresent);
    assign done       = (state_q == StDone);
    assign lit_count  = lit_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader on a reduced 32x24 frame.
// Expected pixels are pushed to a queue from a bench-side frame model when a scan starts.
// They are popped and compared on every handshake.
module tb_vga_frame_reader;

    localparam int W = 32;
    localparam int H = 24;
    localparam int N = W * H;
    localparam int Limit = 8 * N;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       last;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        start;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic [2:0]  pix_colour;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
    logic        busy;
    logic        done;
    logic [14:0] lit_count;

    logic [2:0]  model [N];
    pix_t        exp_q [$];
    int          n_assert = 0;
    int          n_fail   = 0;
    bit          ok;

    vga_frame_reader #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .start      (start),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_last   (pix_last),
        .busy       (busy),
        .done       (done),
        .lit_count  (lit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic plot(input int x, input int y, input logic [2:0] c);
        @(negedge clk);
        vga_plot   = 1'b1;
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = c;
        if (x < W && y < H) model[y*W+x] = c;
        @(negedge clk);
        vga_plot = 1'b0;
    endtask

    // mode 0: black frame; mode 1: colour = (x+y) mod 8
    task automatic fill(input int mode);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                plot(x, y, (mode == 0) ? 3'd0 : 3'((x + y) % 8));
            end
        end
    endtask

    // One scan. rnd: random pix_ready; abort_at: pixel index at which rst is pulsed (-1 none);
    // midwrite: plot (20,20,1) and pulse start when the scan reaches row 10.
    task automatic scan(input bit rnd, input int abort_at, input bit midwrite, output bit completed);
        int   hs;
        int   cyc;
        int   dones;
        int   lit;
        bit   stalled;
        bit   wrote;
        pix_t held;
        pix_t cur;
        pix_t e;
        completed = 1'b0;
        exp_q.delete();
        lit = 0;
        for (int p = 0; p < N; p++) begin
            e.x    = 8'(p % W);
            e.y    = 7'(p / W);
            e.c    = model[p];
            e.last = (p == N - 1);
            exp_q.push_back(e);
            if (model[p] != 3'd0) lit++;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        hs      = 0;
        cyc     = 0;
        dones   = 0;
        stalled = 1'b0;
        wrote   = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (cyc < Limit) begin
            if (done) begin
                dones++;
                break;
            end
            cur.x    = pix_x;
            cur.y    = pix_y;
            cur.c    = pix_colour;
            cur.last = pix_last;
            if (stalled) begin
                chk("stall_valid", 32'(pix_valid), 32'd1);
                chk("stall_hold", 32'(cur), 32'(held));
            end
            if (abort_at >= 0 && pix_valid && hs == abort_at) begin
                rst       = 1'b1;
                pix_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_valid", 32'(pix_valid), 32'd0);
                chk("abort_lit", 32'(lit_count), 32'd0);
                chk("abort_xy", {17'd0, pix_x, pix_y}, 32'd0);
                for (int k = 0; k < 4; k++) begin
                    chk("abort_no_done", 32'(done), 32'd0);
                    @(negedge clk);
                end
                return;
            end
            if (midwrite && !wrote && hs == 10 * W) begin
                wrote      = 1'b1;
                vga_plot   = 1'b1;
                vga_x      = 8'd20;
                vga_y      = 7'd20;
                vga_colour = 3'd1;
                start      = 1'b1;
                if (model[20*W+20] == 3'd0) lit++;
                model[20*W+20] = 3'd1;
                e = exp_q[20*W+20-hs];
                e.c = 3'd1;
                exp_q[20*W+20-hs] = e;
            end
            pix_ready = rnd ? 1'($urandom % 2) : 1'b1;
            if (pix_valid) begin
                if (pix_ready) begin
                    e = exp_q.pop_front();
                    chk("pixel", 32'(cur), 32'(e));
                    hs++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = cur;
                end
            end
            @(negedge clk);
            vga_plot = 1'b0;
            start    = 1'b0;
            cyc++;
        end
        pix_ready = 1'b0;
        chk("done_seen", 32'(dones), 32'd1);
        if (!rnd) chk("scan_cycles", 32'(cyc), 32'(2 * N));
        chk("handshakes", 32'(hs), 32'(N));
        chk("lit_at_done", 32'(lit_count), 32'(lit));
        if (midwrite) chk("midwrite_seen", 32'(wrote), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("lit_hold", 32'(lit_count), 32'(lit));
        completed = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        start      = 1'b0;
        pix_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pix_x", 32'(pix_x), 32'd0);
        chk("rst_pix_y", 32'(pix_y), 32'd0);
        chk("rst_pix_colour", 32'(pix_colour), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_last", 32'(pix_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_lit", 32'(lit_count), 32'd0);
        rst = 1'b0;

        // Black frame, full-rate scan.
        fill(0);
        scan(1'b0, -1, 1'b0, ok);
        chk("black_lit", 32'(lit_count), 32'd0);

        // Three green pixels including both corners.
        plot(16, 12, 3'b010);
        plot(0, 0, 3'b010);
        plot(W - 1, H - 1, 3'b010);
        scan(1'b0, -1, 1'b0, ok);
        chk("green_lit", 32'(lit_count), 32'd3);

        // Reset at (8,5) mid-scan, then a full rescan sees the intact frame.
        scan(1'b0, 5 * W + 8, 1'b0, ok);
        chk("abort_incomplete", 32'(ok), 32'd0);
        scan(1'b0, -1, 1'b0, ok);
        chk("rescan_lit", 32'(lit_count), 32'd3);

        // Out-of-range writes are dropped.
        fill(0);
        plot(W, 10, 3'b111);
        plot(10, H, 3'b111);
        scan(1'b0, -1, 1'b0, ok);
        chk("oor_lit", 32'(lit_count), 32'd0);

        // Patterned frame, random back-pressure, write ahead of scan, start while busy.
        fill(1);
        scan(1'b1, -1, 1'b1, ok);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
